// File: rtl/load_store_unit.sv
// Load/store initiator between the EX/MEM stage and a multi-cycle data memory.
// Converts byte/half/word requests into aligned, byte-enabled bus transfers and stalls until done.
`timescale 1ns/1ps
module load_store_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread_in,
  input  logic        memwrite_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic [2:0]  loadtype_in,
  input  logic [2:0]  strtype_in,
  output logic        stall_out,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic        misalign_out,
  output logic        timeout_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          mem_req_q, mem_we_q;
  logic [31:0]   mem_addr_q, mem_wdata_q, load_data_q;
  logic [3:0]    mem_be_q;
  logic          load_valid_q, misalign_q, timeout_q;
  logic [2:0]    ltype_q;
  logic [1:0]    off_q;

  size_t       size_d;
  logic        req_valid_d, misaligned_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, ext_d;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign req_valid_d = memread_in | memwrite_in;

  // A store wins when both request lines are up, so its funct3 picks the size.
  always_comb begin
    size_d = SZ_WORD;
    if (memwrite_in) begin
      case (strtype_in)
        3'b000:  size_d = SZ_BYTE;
        3'b001:  size_d = SZ_HALF;
        default: size_d = SZ_WORD;
      endcase
    end else begin
      case (loadtype_in)
        3'b000, 3'b100: size_d = SZ_BYTE;
        3'b001, 3'b101: size_d = SZ_HALF;
        default:        size_d = SZ_WORD;
      endcase
    end
  end

  assign misaligned_d = ((size_d == SZ_HALF) && addr_in[0]) ||
                        ((size_d == SZ_WORD) && (addr_in[1:0] != 2'b00));

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = wdata_in;
    case (size_d)
      SZ_BYTE: begin
        be_d    = 4'b0001 << addr_in[1:0];
        wdata_d = {4{wdata_in[7:0]}};
      end
      SZ_HALF: begin
        be_d    = addr_in[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{wdata_in[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = wdata_in;
      end
    endcase
  end

  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (off_q)
      2'd0: byte_sel = mem_rdata[7:0];
      2'd1: byte_sel = mem_rdata[15:8];
      2'd2: byte_sel = mem_rdata[23:16];
      2'd3: byte_sel = mem_rdata[31:24];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ltype_q)
      3'b000:  ext_d = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ext_d = {{16{half_sel[15]}}, half_sel};
      3'b100:  ext_d = {24'h0, byte_sel};
      3'b101:  ext_d = {16'h0, half_sel};
      default: ext_d = mem_rdata;
    endcase
  end

  assign stall_out = ((state_q == S_IDLE) && req_valid_d && !misaligned_d) ||
                     (state_q == S_REQ) || (state_q == S_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      timeout_q    <= 1'b0;
      ltype_q      <= '0;
      off_q        <= '0;
    end else begin
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      timeout_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid_d) begin
            if (misaligned_d) begin
              misalign_q <= 1'b1;
            end else begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= memwrite_in;
              mem_addr_q  <= {addr_in[31:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
              ltype_q     <= loadtype_in;
              off_q       <= addr_in[1:0];
              cnt_q       <= '0;
              state_q     <= S_REQ;
            end
          end
        end
        // An accepted read is not complete yet, so the timeout still applies to it.
        S_REQ: begin
          if (mem_ready && mem_we_q) begin
            mem_req_q <= 1'b0;
            state_q   <= S_DONE;
          end else if (cnt_q == CNT_LAST) begin
            mem_req_q   <= 1'b0;
            timeout_q   <= 1'b1;
            load_data_q <= '0;
            state_q     <= S_DONE;
          end else if (mem_ready) begin
            mem_req_q <= 1'b0;
            cnt_q     <= cnt_q + 1'b1;
            state_q   <= S_WAIT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            load_data_q  <= ext_d;
            load_valid_q <= 1'b1;
            state_q      <= S_DONE;
          end else if (cnt_q == CNT_LAST) begin
            timeout_q   <= 1'b1;
            load_data_q <= '0;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_be         = mem_be_q;
  assign mem_wdata      = mem_wdata_q;
  assign load_data_out  = load_data_q;
  assign load_valid_out = load_valid_q;
  assign misalign_out   = misalign_q;
  assign timeout_out    = timeout_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push expectations, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_load_store_unit;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        memread_in, memwrite_in;
  logic [31:0] addr_in, wdata_in;
  logic [2:0]  loadtype_in, strtype_in;
  logic        stall_out, load_valid_out, misalign_out, timeout_out;
  logic [31:0] load_data_out;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .memread_in(memread_in), .memwrite_in(memwrite_in),
    .addr_in(addr_in), .wdata_in(wdata_in),
    .loadtype_in(loadtype_in), .strtype_in(strtype_in),
    .stall_out(stall_out), .load_data_out(load_data_out),
    .load_valid_out(load_valid_out), .misalign_out(misalign_out),
    .timeout_out(timeout_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  req_t        exp_req[$];
  logic [31:0] exp_load[$];
  int          exp_stall[$];
  int          exp_reqlen[$];
  bit          exp_to[$];
  bit          exp_mis[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, wanted 0x%08h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: DUT event with nothing expected", name);
  endtask

  int stall_run = 0;
  int req_run   = 0;
  bit prev_lv   = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_out === 1'b1) stall_run++;
      else if (stall_run > 0) begin
        if (exp_stall.size() == 0) unexpected("stall_cycles");
        else check("stall_cycles", 32'(stall_run), 32'(exp_stall.pop_front()));
        stall_run = 0;
      end
      if (mem_req === 1'b1) req_run++;
      else if (req_run > 0) begin
        if (exp_reqlen.size() == 0) unexpected("req_cycles");
        else check("req_cycles", 32'(req_run), 32'(exp_reqlen.pop_front()));
        req_run = 0;
      end
      if (mem_req === 1'b1 && mem_ready === 1'b1) begin
        if (exp_req.size() == 0) unexpected("mem_request");
        else begin
          req_t r;
          r = exp_req.pop_front();
          check("mem_we", 32'(mem_we), 32'(r.we));
          check("mem_addr", mem_addr, r.addr);
          if (r.we) begin
            check("mem_be", 32'(mem_be), 32'(r.be));
            check("mem_wdata", mem_wdata, r.wdata);
          end
        end
      end
      if (load_valid_out === 1'b1) begin
        check("load_valid_pulse_prev", 32'(prev_lv), 32'h0);
        if (exp_load.size() == 0) unexpected("load_valid");
        else check("load_data", load_data_out, exp_load.pop_front());
      end
      prev_lv = (load_valid_out === 1'b1);
      if (timeout_out === 1'b1) begin
        if (exp_to.size() == 0) unexpected("timeout");
        else begin
          void'(exp_to.pop_front());
          check("timeout_load_data", load_data_out, 32'h0);
        end
      end
      if (misalign_out === 1'b1) begin
        if (exp_mis.size() == 0) unexpected("misalign");
        else begin
          void'(exp_mis.pop_front());
          check("misalign_no_req", 32'(mem_req), 32'h0);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the IDLE cycle after DONE with the request dropped.
  task automatic run_access(input bit we, input bit rd, input logic [31:0] a, input logic [31:0] wd,
                            input logic [2:0] lt, input logic [2:0] st, input int rdy_dly,
                            input int rv_dly, input logic [31:0] rdat, input bit decoy);
    int cyc = 0;
    int rq  = 0;
    int wc  = 0;
    bit seen = 1'b0;
    bit acc  = 1'b0;
    bit fin  = 1'b0;
    memwrite_in = we; memread_in = rd; addr_in = a; wdata_in = wd;
    loadtype_in = lt; strtype_in = st;
    while (!fin && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      if (mem_req) begin
        seen = 1'b1;
        if (rdy_dly >= 0 && rq == rdy_dly) begin
          mem_ready = 1'b1;
          acc = 1'b1;
          if (decoy) begin mem_rvalid = 1'b1; mem_rdata = ~rdat; end
        end
        rq++;
      end else if (seen && !stall_out) begin
        fin = 1'b1;
      end else if (acc && rd && !we) begin
        if (wc == rv_dly) begin mem_rvalid = 1'b1; mem_rdata = rdat; end
        wc++;
      end
    end
    if (!fin) begin
      n_checks++; n_fail++;
      $display("FAIL access_bound: addr 0x%08h did not complete within 100 cycles", a);
    end
    @(posedge clk); #1;
    memwrite_in = 1'b0; memread_in = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] st,
                       input bit also_rd, input int rdy,
                       input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wd,
                       input int e_stall);
    req_t r;
    r.we = 1'b1; r.addr = e_addr; r.be = e_be; r.wdata = e_wd;
    exp_req.push_back(r);
    exp_stall.push_back(e_stall);
    exp_reqlen.push_back(rdy + 1);
    run_access(1'b1, also_rd, a, wd, 3'b010, st, rdy, 0, 32'h0, 1'b0);
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] lt, input int rdy, input int rv,
                      input logic [31:0] rdat, input bit decoy,
                      input logic [31:0] e_addr, input logic [31:0] e_data, input int e_stall);
    req_t r;
    r.we = 1'b0; r.addr = e_addr; r.be = 4'h0; r.wdata = 32'h0;
    exp_req.push_back(r);
    exp_load.push_back(e_data);
    exp_stall.push_back(e_stall);
    exp_reqlen.push_back(rdy + 1);
    run_access(1'b0, 1'b1, a, 32'h0, lt, 3'b010, rdy, rv, rdat, decoy);
  endtask

  task automatic misaligned(input bit we, input logic [31:0] a, input logic [2:0] lt, input logic [2:0] st);
    memwrite_in = we; memread_in = !we; addr_in = a; loadtype_in = lt; strtype_in = st;
    exp_mis.push_back(1'b1);
    @(negedge clk);
    check("misalign_stall", 32'(stall_out), 32'h0);
    @(posedge clk); #1;
    memwrite_in = 1'b0; memread_in = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    memread_in = 1'b0; memwrite_in = 1'b0; addr_in = '0; wdata_in = '0;
    loadtype_in = '0; strtype_in = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_be", 32'(mem_be), 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_load_data", load_data_out, 32'h0);
    check("rst_load_valid", 32'(load_valid_out), 32'h0);
    check("rst_misalign", 32'(misalign_out), 32'h0);
    check("rst_timeout", 32'(timeout_out), 32'h0);
    check("rst_stall", 32'(stall_out), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    store(32'h8,  32'hDEADBEEF, 3'b010, 1'b0, 0, 32'h8,  4'b1111, 32'hDEADBEEF, 2);
    store(32'h13, 32'h000000A5, 3'b000, 1'b0, 2, 32'h10, 4'b1000, 32'hA5A5A5A5, 4);
    store(32'h22, 32'h1234BEEF, 3'b001, 1'b0, 0, 32'h20, 4'b1100, 32'hBEEFBEEF, 2);
    store(32'h30, 32'hCAFEF00D, 3'b010, 1'b1, 1, 32'h30, 4'b1111, 32'hCAFEF00D, 3);

    load(32'h6,  3'b000, 0, 0, 32'h80FF1234, 1'b0, 32'h4,  32'hFFFFFFFF, 3);
    load(32'h6,  3'b101, 0, 2, 32'h80FF1234, 1'b0, 32'h4,  32'h000080FF, 5);
    load(32'h6,  3'b001, 1, 0, 32'h80FF1234, 1'b1, 32'h4,  32'hFFFF80FF, 4);
    load(32'h13, 3'b100, 0, 1, 32'hC3000000, 1'b0, 32'h10, 32'h000000C3, 4);
    load(32'h40, 3'b011, 0, 0, 32'h12345678, 1'b0, 32'h40, 32'h12345678, 3);

    misaligned(1'b0, 32'h2, 3'b010, 3'b010);
    misaligned(1'b0, 32'h5, 3'b101, 3'b010);
    misaligned(1'b1, 32'h3, 3'b000, 3'b001);

    // Slave never accepts: TIMEOUT cycles of mem_req, then abandon.
    exp_stall.push_back(TO + 1);
    exp_reqlen.push_back(TO);
    exp_to.push_back(1'b1);
    run_access(1'b0, 1'b1, 32'h50, 32'h0, 3'b010, 3'b010, -1, 0, 32'h0, 1'b0);

    // Reset while waiting for read data; the late rvalid must be ignored.
    begin
      req_t r;
      r.we = 1'b0; r.addr = 32'h60; r.be = 4'h0; r.wdata = 32'h0;
      exp_req.push_back(r);
      exp_stall.push_back(3);
      exp_reqlen.push_back(1);
      memread_in = 1'b1; addr_in = 32'h60; loadtype_in = 3'b010;
      @(posedge clk); #1;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      rst = 1'b1; memread_in = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD0001;
      @(negedge clk);
      check("post_rst_mem_req", 32'(mem_req), 32'h0);
      check("post_rst_stall", 32'(stall_out), 32'h0);
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      @(negedge clk);
      check("post_rst_load_valid", 32'(load_valid_out), 32'h0);
      check("post_rst_load_data", load_data_out, 32'h0);
      @(posedge clk); #1;
    end

    store(32'h70, 32'h0BADF00D, 3'b010, 1'b0, 0, 32'h70, 4'b1111, 32'h0BADF00D, 2);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("left_req", 32'(exp_req.size()), 32'h0);
    check("left_load", 32'(exp_load.size()), 32'h0);
    check("left_stall", 32'(exp_stall.size()), 32'h0);
    check("left_reqlen", 32'(exp_reqlen.size()), 32'h0);
    check("left_timeout", 32'(exp_to.size()), 32'h0);
    check("left_misalign", 32'(exp_mis.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Pipeline-side initiator for data memory accesses, sitting between the EX/MEM register and a multi-cycle data memory or bus slave. It turns LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-aligned requests with byte enables over a req/ready + rvalid handshake. It stalls the pipeline until each access completes, then returns sign- or zero-extended load data. It also flags misaligned accesses and memory timeouts.

## Interface
- TIMEOUT, 64: cycles allowed in REQ+WAIT before the access is abandoned (≥2).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- memread_in  in  1  load request from the pipeline, held stable while stall_out=1.
- memwrite_in  in  1  store request; takes priority if asserted together with memread_in.
- addr_in  in  32  byte address (ALU result).
- wdata_in  in  32  store data (rs2).
- loadtype_in  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other values are treated as LW.
- strtype_in  in  3  funct3: 000 SB, 001 SH, 010 SW; other values are treated as SW.
- stall_out  out  1  freeze the pipeline.
- load_data_out  out  32  extended load result, valid while load_valid_out=1.
- load_valid_out  out  1  one-cycle pulse when a load completes.
- misalign_out  out  1  one-cycle pulse when a request is misaligned.
- timeout_out  out  1  one-cycle pulse when an access is abandoned.
- mem_req  out  1  request valid.
- mem_we  out  1  1 = write.
- mem_addr  out  32  {addr[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ready  in  1  slave accepts the request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, valid and aligned request:
  - Register the address, type, byte enables, write data and the we bit.
  - Go to REQ.
- IDLE, misaligned request:
  - A halfword is misaligned when addr[0]=1. A word is misaligned when addr[1:0]≠0.
  - Pulse misalign_out; issue no memory request; do not stall; stay in IDLE.
- REQ:
  - mem_req=1 and all mem_* outputs are held stable until mem_ready=1.
  - On accept: a write goes to DONE, a read goes to WAIT.
- WAIT:
  - On mem_rvalid=1, capture the extended mem_rdata and go to DONE.
  - mem_rvalid in any other state is ignored.
- DONE:
  - stall_out=0 and no new request is accepted, so the still-held instruction is not re-issued.
  - A load pulses load_valid_out.
  - Next state is IDLE.
- Timeout:
  - A counter resets on entering REQ and counts every cycle in REQ or WAIT.
  - When it reaches TIMEOUT-1 without completion: drop mem_req, pulse timeout_out in DONE, set load_data_out=0, go to DONE.
- Store lanes:
  - SB: wdata[7:0] replicated ×4; be = 0001<<addr[1:0].
  - SH: wdata[15:0] replicated ×2; be = 0011 if addr[1]=0, else 1100.
  - SW: be = 1111.
- Load extraction:
  - Byte select is addr[1:0]; halfword select is addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- stall_out = (IDLE and valid aligned request) or REQ or WAIT. It is combinational from IDLE.
- Reset values:
  - State IDLE; counter 0.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_be, mem_wdata, load_data_out, load_valid_out, misalign_out, timeout_out. stall_out follows its combinational term and is 0 when no request is present.

## Timing
- Store with mem_ready=1 on the first REQ cycle:
  - Cycle0 IDLE, stall=1.
  - Cycle1 REQ, accept.
  - Cycle2 DONE, stall=0. Pipeline stalled for 2 cycles.
- Load with ready=1 and rvalid one cycle later:
  - Cycle0 IDLE, cycle1 REQ, cycle2 WAIT with rvalid, cycle3 DONE with load_valid_out=1. 3 stall cycles.
- mem_rvalid in the same cycle as mem_ready is not accepted; read data is valid no earlier than the cycle after accept.
- Synchronous rst mid-access:
  - State is IDLE and mem_req=0 from the next edge.
  - A late mem_rvalid after reset is ignored.
- load_data_out holds its last value outside DONE, except that rst clears it.

## Test plan
- SW 0xDEADBEEF at addr 0x8, ready=1 → mem_addr=0x8, mem_be=1111, mem_we=1, stall high for exactly 2 cycles, DONE on cycle2.
- SB 0x000000A5 at addr 0x13 → mem_addr=0x10, mem_be=1000, mem_wdata=0xA5A5A5A5.
- LB at addr 0x6, mem_rdata=0x80FF1234 → load_data_out=0xFFFFFFFF. LHU at addr 0x6 with the same data → 0x000080FF, load_valid_out a one-cycle pulse.
- LW at addr 0x2 → misalign_out pulse, mem_req never asserted, stall_out=0.
- LW with mem_ready held 0, TIMEOUT=8 → mem_req high 8 cycles then low, timeout_out pulse, load_data_out=0, stall released.
- rst asserted while in WAIT, then mem_rvalid=1 → no load_valid_out, state IDLE, mem_req=0.
